// File: rtl/data_mem_arbiter.sv
// Arbitrates one data memory between single-word CPU accesses and DMA bursts.
// CPU is served combinationally in IDLE; a DMA win latches a burst that then owns the memory.
module data_mem_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWData,
    output logic        CpuAck,
    output logic [31:0] CpuRData,
    input  logic        DmaReq,
    input  logic        DmaWrite,
    input  logic [31:0] DmaAddr,
    input  logic [3:0]  DmaLen,
    input  logic [31:0] DmaWData,
    output logic        DmaAck,
    output logic [31:0] DmaRData,
    output logic        DmaDone,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_BURST   = 1'b1;
    localparam logic [2:0] STARVE_MAX = 3'd4;

    // Zero-length bursts become one beat; anything above eight is capped at eight.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        logic [3:0] res;
        if (len == 4'd0) begin
            res = 4'd1;
        end else if (len > 4'd8) begin
            res = 4'd8;
        end else begin
            res = len;
        end
        return res;
    endfunction

    logic [0:0]  state_r;
    logic [2:0]  starve_r;
    logic [3:0]  beat_r;
    logic [3:0]  len_r;
    logic [31:0] base_r;
    logic        write_r;

    logic        cpu_win_s;
    logic        dma_win_s;
    logic        in_burst_s;
    logic        last_beat_s;
    logic [31:0] dma_base_s;

    assign dma_base_s = DmaAddr & 32'hFFFF_FFFC;

    // Grant decision; everything is gated by reset so nothing is issued while it is held.
    always_comb begin
        cpu_win_s  = 1'b0;
        dma_win_s  = 1'b0;
        in_burst_s = 1'b0;
        if (!Reset) begin
            in_burst_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            cpu_win_s = CpuReq && (!DmaReq || (starve_r < STARVE_MAX));
            dma_win_s = DmaReq && (!CpuReq || (starve_r == STARVE_MAX));
        end else begin
            in_burst_s = 1'b1;
        end
        last_beat_s = in_burst_s && (beat_r == (len_r - 4'd1));
    end

    // Memory-side and requester-side outputs for the granted access.
    always_comb begin
        CpuAck       = 1'b0;
        CpuRData     = 32'd0;
        DmaAck       = 1'b0;
        DmaRData     = 32'd0;
        DmaDone      = 1'b0;
        MemAddress   = 32'd0;
        MemWriteData = 32'd0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        if (cpu_win_s) begin
            CpuAck       = 1'b1;
            MemAddress   = CpuAddr;
            MemWriteData = CpuWData;
            MemWrite     = CpuWrite;
            MemRead      = !CpuWrite;
            CpuRData     = CpuWrite ? 32'd0 : MemReadData;
        end else if (in_burst_s) begin
            DmaAck       = 1'b1;
            DmaDone      = last_beat_s;
            MemAddress   = base_r + {26'd0, beat_r, 2'b00};
            MemWriteData = DmaWData;
            MemWrite     = write_r;
            MemRead      = !write_r;
            DmaRData     = write_r ? 32'd0 : MemReadData;
        end else begin
            MemRead = 1'b0;
        end
    end

    // State, starvation counter and burst context.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r  <= ST_IDLE;
            starve_r <= 3'd0;
            beat_r   <= 4'd0;
            len_r    <= 4'd0;
            base_r   <= 32'd0;
            write_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dma_win_s) begin
                        state_r  <= ST_BURST;
                        base_r   <= dma_base_s;
                        write_r  <= DmaWrite;
                        len_r    <= clamp_len(DmaLen);
                        beat_r   <= 4'd0;
                        starve_r <= 3'd0;
                    end else if (!DmaReq) begin
                        starve_r <= 3'd0;
                    end else if (cpu_win_s && (starve_r < STARVE_MAX)) begin
                        starve_r <= starve_r + 3'd1;
                    end else begin
                        starve_r <= starve_r;
                    end
                end
                ST_BURST: begin
                    if (last_beat_s) begin
                        state_r <= ST_IDLE;
                        beat_r  <= 4'd0;
                    end else begin
                        beat_r <= beat_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboarded bench for data_mem_arbiter: a transaction-level model predicts every cycle's
// bus outputs, a monitor compares them at the falling edge.
module tb_data_mem_arbiter;

    typedef struct packed {
        logic        cpu_ack;
        logic [31:0] cpu_rdata;
        logic        dma_ack;
        logic [31:0] dma_rdata;
        logic        dma_done;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        mem_write;
        logic        mem_read;
    } obs_t;

    logic        Clk;
    logic        Reset;
    logic        CpuReq, CpuWrite;
    logic [31:0] CpuAddr, CpuWData;
    logic        CpuAck;
    logic [31:0] CpuRData;
    logic        DmaReq, DmaWrite;
    logic [31:0] DmaAddr;
    logic [3:0]  DmaLen;
    logic [31:0] DmaWData;
    logic        DmaAck;
    logic [31:0] DmaRData;
    logic        DmaDone;
    logic [31:0] MemAddress, MemWriteData;
    logic        MemWrite, MemRead;
    logic [31:0] MemReadData;

    data_mem_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuAck(CpuAck), .CpuRData(CpuRData),
        .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaAddr(DmaAddr), .DmaLen(DmaLen),
        .DmaWData(DmaWData), .DmaAck(DmaAck), .DmaRData(DmaRData), .DmaDone(DmaDone),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemReadData(MemReadData)
    );

    // Memory device: 256 words, aliased on address bits [9:2].
    logic [31:0] mem [0:255];
    assign MemReadData = mem[MemAddress[9:2]];
    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddress[9:2]] <= MemWriteData;
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] beats_q [$];
    logic        bwrite_m;
    int          starve_m;
    obs_t        exp_q [$];
    int          tests;
    int          failed;

    task automatic step(input logic rst, input logic creq, input logic cwr,
                        input logic [31:0] caddr, input logic [31:0] cwd,
                        input logic dreq, input logic dwr, input logic [31:0] daddr,
                        input logic [3:0] dlen, input logic [31:0] dwd);
        obs_t        e;
        int          n;
        logic [31:0] a;
        logic [31:0] base;
        @(posedge Clk);
        #1;
        Reset = rst; CpuReq = creq; CpuWrite = cwr; CpuAddr = caddr; CpuWData = cwd;
        DmaReq = dreq; DmaWrite = dwr; DmaAddr = daddr; DmaLen = dlen; DmaWData = dwd;
        e = '0;
        if (!rst) begin
            starve_m = 0;
            beats_q.delete();
        end else if (beats_q.size() > 0) begin
            a           = beats_q.pop_front();
            e.dma_ack   = 1'b1;
            e.mem_addr  = a;
            e.mem_wdata = dwd;
            e.mem_write = bwrite_m;
            e.mem_read  = !bwrite_m;
            e.dma_done  = (beats_q.size() == 0);
            if (bwrite_m) ref_mem[a[9:2]] = dwd;
            else          e.dma_rdata = ref_mem[a[9:2]];
        end else if (creq && (!dreq || starve_m < 4)) begin
            e.cpu_ack   = 1'b1;
            e.mem_addr  = caddr;
            e.mem_wdata = cwd;
            e.mem_write = cwr;
            e.mem_read  = !cwr;
            if (cwr) ref_mem[caddr[9:2]] = cwd;
            else     e.cpu_rdata = ref_mem[caddr[9:2]];
            starve_m = dreq ? ((starve_m < 4) ? starve_m + 1 : 4) : 0;
        end else if (dreq) begin
            n    = (dlen == 4'd0) ? 1 : ((dlen > 4'd8) ? 8 : int'(dlen));
            base = daddr & 32'hFFFF_FFFC;
            for (int k = 0; k < n; k++) beats_q.push_back(base + 32'(4 * k));
            bwrite_m = dwr;
            starve_m = 0;
        end else begin
            starve_m = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic cpu(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        step(1'b1, 1'b1, wr, addr, data, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic dma_start(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, wr, addr, len, 32'd0);
    endtask

    task automatic dma_beat(input logic [31:0] wd);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_0000, 4'd5, wd);
    endtask

    // Monitor: one comparison per predicted cycle.
    initial begin
        obs_t e;
        obs_t act;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{CpuAck, CpuRData, DmaAck, DmaRData, DmaDone,
                        MemAddress, MemWriteData, MemWrite, MemRead};
                tests++;
                if (act !== e) begin
                    failed++;
                    $display("FAIL bus @%0t: got cack=%b crd=%h dack=%b drd=%h done=%b addr=%h wd=%h w=%b r=%b, want cack=%b crd=%h dack=%b drd=%h done=%b addr=%h wd=%h w=%b r=%b",
                             $time, act.cpu_ack, act.cpu_rdata, act.dma_ack, act.dma_rdata,
                             act.dma_done, act.mem_addr, act.mem_wdata, act.mem_write, act.mem_read,
                             e.cpu_ack, e.cpu_rdata, e.dma_ack, e.dma_rdata, e.dma_done,
                             e.mem_addr, e.mem_wdata, e.mem_write, e.mem_read);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; failed = 0; starve_m = 0; bwrite_m = 1'b0;
        Reset = 1'b0; CpuReq = 1'b0; CpuWrite = 1'b0; CpuAddr = 32'd0; CpuWData = 32'd0;
        DmaReq = 1'b0; DmaWrite = 1'b0; DmaAddr = 32'd0; DmaLen = 4'd0; DmaWData = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        end

        repeat (3) idle(1'b0);
        idle(1'b1);

        // CPU write then read back
        cpu(1'b1, 32'h8, 32'hDEAD_BEEF);
        cpu(1'b0, 32'h8, 32'd0);

        // 4-beat DMA write, confirmed by CPU reads
        dma_start(1'b1, 32'h100, 4'd4);
        dma_beat(32'h11); dma_beat(32'h22); dma_beat(32'h33); dma_beat(32'h44);
        for (int i = 0; i < 4; i++) cpu(1'b0, 32'h100 + 32'(4 * i), 32'd0);

        // Contention: both held until the burst finishes
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 1'b0, 32'h104, 32'd0, 1'b1, 1'b1, 32'h500, 4'd3, 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 3; i++) cpu(1'b0, 32'h500 + 32'(4 * i), 32'd0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 1'b1, 1'b0, 32'h600, 4'd1, 32'd0);

        // Clamp and wrap
        dma_start(1'b0, 32'h203, 4'd0);
        dma_beat(32'd0);
        idle(1'b1);
        dma_start(1'b0, 32'h40, 4'd15);
        for (int i = 0; i < 8; i++) dma_beat(32'd0);
        idle(1'b1);
        dma_start(1'b1, 32'hFFFF_FFFC, 4'd2);
        dma_beat(32'h1234_5678); dma_beat(32'h9ABC_DEF0);
        cpu(1'b0, 32'hFFFF_FFFC, 32'd0);
        cpu(1'b0, 32'h0, 32'd0);

        // Reset during beat 2 of an 8-beat write
        dma_start(1'b1, 32'h300, 4'd8);
        dma_beat(32'hB0); dma_beat(32'hB1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'hB2);
        idle(1'b1);
        for (int i = 0; i < 8; i++) cpu(1'b0, 32'h300 + 32'(4 * i), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom);
        end
        // Drain any open burst, then read back the whole memory
        for (int i = 0; i < 10; i++) idle(1'b1);
        for (int i = 0; i < 256; i++) cpu(1'b0, 32'(4 * i), 32'd0);

        @(negedge Clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-low reset; sampled only on the Clk rising edge.
REQ-003 SHALL have ports CpuReq (in, 1), CpuWrite (in, 1), CpuAddr (in, 32), CpuWData (in, 32): CPU single-word request.
REQ-004 SHALL have ports CpuAck (out, 1) and CpuRData (out, 32): CPU served this cycle, read data.
REQ-005 SHALL have ports DmaReq (in, 1), DmaWrite (in, 1), DmaAddr (in, 32), DmaLen (in, 4), DmaWData (in, 32): DMA burst request, start address, beat count, per-beat write data.
REQ-006 SHALL have ports DmaAck (out, 1), DmaRData (out, 32), DmaDone (out, 1): beat served, read data, last-beat pulse.
REQ-007 SHALL have ports MemAddress (out, 32), MemWriteData (out, 32), MemWrite (out, 1), MemRead (out, 1), MemReadData (in, 32): data-memory side; memory reads combinationally, writes on rising edge.

Function
REQ-008 SHALL implement two states: IDLE (CPU service, arbitration) and BURST (DMA beats).
REQ-009 In IDLE, CPU SHALL win when CpuReq=1 and (DmaReq=0 or StarveCnt<4); DMA SHALL win when DmaReq=1 and (CpuReq=0 or StarveCnt=4).
REQ-010 CPU win SHALL be zero-latency: same cycle MemAddress=CpuAddr, MemWriteData=CpuWData, MemWrite=CpuWrite, MemRead=!CpuWrite, CpuAck=1.
REQ-011 CpuRData SHALL equal MemReadData when CpuAck=1 and CpuWrite=0, else 0.
REQ-012 StarveCnt (3 bits) SHALL increment, saturating at 4, on each CPU win while DmaReq=1; SHALL clear when DmaReq=0 in IDLE or on DMA win.
REQ-013 DMA win SHALL latch Base={DmaAddr[31:2],2'b00}, Write=DmaWrite, Len=clamp(DmaLen) where 0->1 and >8->8; transition to BURST; no memory access and CpuAck=0 in the win cycle.
REQ-014 In BURST each cycle SHALL perform one beat at MemAddress=Base+4*Beat (32-bit modulo 2^32 wrap), with DmaAck=1, MemWrite=Write, MemRead=!Write, MemWriteData=DmaWData.
REQ-015 DmaRData SHALL equal MemReadData when DmaAck=1 and Write=0, else 0.
REQ-016 Beat counter (4 bits) SHALL run 0..Len-1; on beat Len-1 DmaDone=1 for exactly that cycle and state returns to IDLE.
REQ-017 BURST SHALL ignore DmaReq, DmaAddr, DmaLen, DmaWrite changes; burst always completes.
REQ-018 CpuAck SHALL be 0 throughout BURST; CPU stall latency SHALL be at most 1+8 cycles per burst.
REQ-019 When no access is granted, MemRead, MemWrite, MemAddress, MemWriteData, CpuAck, DmaAck, DmaDone, CpuRData, DmaRData SHALL all be 0.
REQ-020 DmaReq still high in the DmaDone cycle SHALL be arbitrated afresh in the following IDLE cycle (requester drops DmaReq with DmaDone to avoid a repeat burst).
REQ-021 MemWrite and MemRead SHALL never both be 1.

Reset
REQ-022 Reset=0 at a rising edge SHALL force IDLE, StarveCnt=0, beat counter=0, latched Base/Len/Write=0.
REQ-023 While Reset=0, all outputs SHALL be 0 and no memory access SHALL be issued.
REQ-024 Reset mid-burst SHALL abort the burst with no DmaDone; remaining beats are not performed.

Verification
REQ-025 CPU only: CpuReq=1, CpuWrite=1, CpuAddr=0x8, CpuWData=0xDEADBEEF; next cycle read 0x8 -> CpuAck=1 both cycles, CpuRData=0xDEADBEEF.
REQ-026 DMA write burst: DmaAddr=0x100, DmaLen=4, DmaWData=0x11..0x44 -> win cycle idle, then 4 beats at 0x100/0x104/0x108/0x10C, DmaDone on 4th beat; CPU reads confirm data.
REQ-027 Contention: CpuReq and DmaReq held high -> 4 CPU acks, 1 idle win cycle, Len DMA beats, CPU resumes; StarveCnt back to 0.
REQ-028 Clamp/wrap: DmaLen=0 -> 1 beat; DmaLen=15 -> 8 beats; DmaAddr=0xFFFFFFFC, Len=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-029 Reset asserted on beat 2 of an 8-beat write -> no DmaDone, outputs 0 next cycle, only beats 0-1 written.
